// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//   Instruction-memory responder for the 8-bit accumulator CPU. A host streams
//   a program into a 2**ADDR_W x DATA_W store over a valid/ready byte
//   handshake. The CPU is held in reset (cpu_rst=0) until the program is
//   complete, then released to fetch combinationally from the store.
//
//   Optional build macro: IMEM_LOADER_CHECKSUM_EN
//     Adds a CHK state that accepts one trailing checksum byte. The load is
//     accepted only if (sum of data bytes + checksum) mod 256 == 0. Otherwise
//     load_err is raised and the block returns to IDLE.
//
// Ports
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   load_start   1-cycle pulse; begins a load (honoured in IDLE and RUN)
//   load_len     byte count sampled with load_start; 0 means 2**ADDR_W
//   load_valid   host byte valid
//   load_data    host byte
//   load_ready   block accepts a byte this cycle
//   im_addr_bus  CPU fetch address (PC)
//   im_data_bus  instruction at im_addr_bus in RUN, NOP_WORD otherwise
//   cpu_rst      active-low CPU reset; 1 only in RUN
//   load_done    high while in RUN
//   load_err     checksum failure flag (tied 0 without the macro)
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int                 ADDR_W   = 5,
  parameter int                 DATA_W   = 8,
  parameter logic [DATA_W-1:0]  NOP_WORD = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic [ADDR_W:0]   load_len,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  input  logic [ADDR_W-1:0] im_addr_bus,
  output logic [DATA_W-1:0] im_data_bus,
  output logic              cpu_rst,
  output logic              load_done,
  output logic              load_err
);

  localparam int                DEPTH    = 2 ** ADDR_W;
  localparam logic [ADDR_W:0]   FULL_LEN = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, LOAD, CHK, RUN} state_t;
`else
  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;
`endif

  state_t              state, next_state;
  logic [ADDR_W-1:0]   wr_addr;
  logic [ADDR_W:0]     cnt;
  logic [ADDR_W:0]     len;
  logic                start_load;
  logic                wr_en;
  logic [DATA_W-1:0]   mem [DEPTH];

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0]   sum;
  logic [DATA_W-1:0]   chk_total;
  logic                chk_fail;
  logic                err_q;
`endif

  // Only data bytes in LOAD are stored; the checksum byte in CHK is not.
  assign wr_en = (state == LOAD) && load_ready && load_valid;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      // NOTE: all clocked state uses non-blocking (<=) so every register sees
      // the pre-edge values of its neighbours, independent of block order.
      state <= next_state;
    end
  end

  // Next-state and Moore outputs.
  always_comb begin
    // NOTE: every signal written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    next_state = state;
    load_ready = 1'b0;
    cpu_rst    = 1'b0;
    load_done  = 1'b0;
    start_load = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk_fail   = 1'b0;
    chk_total  = sum + load_data;
`endif
    case (state)
      IDLE: begin
        if (load_start) begin
          start_load = 1'b1;
          next_state = LOAD;
        end
      end
      LOAD: begin
        // Ready drops once the count is met so no surplus byte slips in
        // during the cycle spent leaving LOAD.
        if (cnt == len) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          next_state = CHK;
`else
          next_state = RUN;
`endif
        end else begin
          load_ready = 1'b1;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK: begin
        load_ready = 1'b1;
        if (load_valid) begin
          if (chk_total == '0) begin
            next_state = RUN;
          end else begin
            chk_fail   = 1'b1;
            next_state = IDLE;
          end
        end
      end
`endif
      RUN: begin
        cpu_rst   = 1'b1;
        load_done = 1'b1;
        if (load_start) begin
          start_load = 1'b1;
          next_state = LOAD;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Load bookkeeping: write pointer, accepted-byte count, latched length.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_addr <= '0;
      cnt     <= '0;
      len     <= '0;
    end else if (start_load) begin
      wr_addr <= '0;
      cnt     <= '0;
      len     <= (load_len == '0) ? FULL_LEN : load_len;
    end else if (wr_en) begin
      wr_addr <= wr_addr + ADDR_ONE;
      cnt     <= cnt + CNT_ONE;
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  // Running checksum and sticky error flag (cleared only by a new load).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sum   <= '0;
      err_q <= 1'b0;
    end else if (start_load) begin
      sum   <= '0;
      err_q <= 1'b0;
    end else begin
      if (wr_en) sum <= sum + load_data;
      if (chk_fail) err_q <= 1'b1;
    end
  end

  assign load_err = err_q;
`else
  assign load_err = 1'b0;
`endif

  // Program store.
  // NOTE: the array has no reset so it maps onto plain RAM; its contents
  // survive rst and are hidden by the RUN gating on the read port.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= load_data;
  end

  // Combinational fetch, served only once the program is complete.
  always_comb begin
    im_data_bus = NOP_WORD;
    if (state == RUN) im_data_bus = mem[im_addr_bus];
  end

endmodule
